// File: rtl/imem_rr_arbiter_if.sv
// Bundle of the two requester ports and the instruction-memory port.
// The slave modport belongs to the arbiter; master is the requester/memory side.
interface imem_rr_arbiter_if #(
    parameter int AW = 6
);
    logic          m0_req;
    logic [31:0]   m0_addr;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [31:0]   m0_rdata;
    logic          m0_err;

    logic          m1_req;
    logic [31:0]   m1_addr;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [31:0]   m1_rdata;
    logic          m1_err;

    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;

    modport slave (
        input  m0_req, m0_addr, m1_req, m1_addr, mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output mem_en, mem_addr
    );

    modport master (
        output m0_req, m0_addr, m1_req, m1_addr, mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  mem_en, mem_addr
    );
endinterface

// File: rtl/imem_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous instruction memory between
// CPU fetch (port 0) and debug readback (port 1), with range-checked addresses.
module imem_rr_arbiter #(
    parameter int SIZE       = 64,
    parameter int RD_LATENCY = 1
) (
    input logic              clk,
    input logic              rst,
    imem_rr_arbiter_if.slave bus
);
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic                  last_gnt_q, last_gnt_d;
    logic                  gnt0, gnt1, any_gnt, in_range;
    logic [31:0]           sel_addr;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [RD_LATENCY-1:0] id_q, id_d;
    logic [RD_LATENCY-1:0] err_q, err_d;
    logic                  rsp_vld, rsp_id, rsp_err;

    // Under contention the port that did not win last time gets the grant.
    always_comb begin
        gnt0       = bus.m0_req & (~bus.m1_req | last_gnt_q);
        gnt1       = bus.m1_req & (~bus.m0_req | ~last_gnt_q);
        any_gnt    = gnt0 | gnt1;
        sel_addr   = gnt1 ? bus.m1_addr : bus.m0_addr;
        in_range   = sel_addr < 32'(SIZE);
        last_gnt_d = any_gnt ? gnt1 : last_gnt_q;
    end

    assign bus.m0_gnt   = gnt0;
    assign bus.m1_gnt   = gnt1;
    assign bus.mem_en   = any_gnt & in_range;
    assign bus.mem_addr = (any_gnt & in_range) ? sel_addr[AW-1:0] : '0;

    // Tag pipeline is exactly as deep as the memory latency, so the last
    // stage lines up with the matching mem_rdata word.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign vld_d[gi] = any_gnt;
                assign id_d[gi]  = gnt1;
                assign err_d[gi] = any_gnt & ~in_range;
            end else begin : g_shift
                assign vld_d[gi] = vld_q[gi-1];
                assign id_d[gi]  = id_q[gi-1];
                assign err_d[gi] = err_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            vld_q      <= '0;
            id_q       <= '0;
            err_q      <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            vld_q      <= vld_d;
            id_q       <= id_d;
            err_q      <= err_d;
        end
    end

    assign rsp_vld = vld_q[RD_LATENCY-1];
    assign rsp_id  = id_q[RD_LATENCY-1];
    assign rsp_err = err_q[RD_LATENCY-1];

    assign bus.m0_rvalid = rsp_vld & ~rsp_id;
    assign bus.m0_err    = rsp_vld & ~rsp_id & rsp_err;
    assign bus.m0_rdata  = (rsp_vld & ~rsp_id & ~rsp_err) ? bus.mem_rdata : 32'h0;

    assign bus.m1_rvalid = rsp_vld & rsp_id;
    assign bus.m1_err    = rsp_vld & rsp_id & rsp_err;
    assign bus.m1_rdata  = (rsp_vld & rsp_id & ~rsp_err) ? bus.mem_rdata : 32'h0;
endmodule
